cam_capture_stream: RTL and testbench

- Parametrised successor to the camera capture front end.
- Synchronises a DVP-style camera bus (pclk/vsync/href/data) into the pix_clk domain and packs BYTES_PER_PIXEL bytes into one pixel word.
- Emits an AXI-Stream-like pixel stream. TUSER marks the first pixel of a frame; TLAST marks the last pixel of a line.
- Adds single-shot/continuous modes, pixel coordinates, frame counting, and geometry error checking. Sits between the camera pins and the YCbCr parser/encoder.

---
 rtl/cam_pkg.sv | 14 +
 rtl/cam_bus_sync.sv | 43 ++++
 rtl/cam_capture_stream.sv | 146 ++++++++++++++
 tb/tb_cam_capture_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM encoding, pixel width helper and default sensor geometry
package cam_pkg;
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_SOF   = 2'd1,
      ST_CAPTURE    = 2'd2,
      ST_FRAME_DONE = 2'd3
   } cam_state_t;
   localparam int OV7670_WIDTH  = 640;
   localparam int OV7670_HEIGHT = 480;
   function automatic int pix_w(input int data_w, input int bpp);
      return data_w * bpp;
   endfunction
endpackage

// File: rtl/cam_bus_sync.sv
// cam_bus_sync: brings the asynchronous DVP bus into the pixel clock domain as level and edge strobes
module cam_bus_sync #(
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              pclk_i,
   input  logic              vsync_i,
   input  logic              href_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              href_o,
   output logic              pclk_rise_o,
   output logic              href_rise_o,
   output logic              href_fall_o,
   output logic              vsync_rise_o,
   output logic              vsync_fall_o
);
   logic [2:0]        s1_q, s2_q;
   logic [DATA_W-1:0] data_q;
   // two-flop synchronisers for {pclk, vsync, href}; data sampled beside the first stage so it lines up with pclk_rise
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         s1_q   <= '0;
         s2_q   <= '0;
         data_q <= '0;
      end else begin
         s1_q   <= {pclk_i, vsync_i, href_i};
         s2_q   <= s1_q;
         data_q <= data_i;
      end
   end
   // edges seen between the two stages, one cycle wide
   always_comb begin
      data_o       = data_q;
      href_o       = s1_q[0];
      pclk_rise_o  = s1_q[2] & ~s2_q[2];
      vsync_rise_o = s1_q[1] & ~s2_q[1];
      vsync_fall_o = ~s1_q[1] & s2_q[1];
      href_rise_o  = s1_q[0] & ~s2_q[0];
      href_fall_o  = ~s1_q[0] & s2_q[0];
   end
endmodule

// File: rtl/cam_capture_stream.sv
// cam_capture_stream: DVP camera bus to AXI-Stream-like pixel stream with framing, coordinates and geometry checks
module cam_capture_stream
   import cam_pkg::*;
#(
   parameter int DATA_W            = 8,
   parameter int BYTES_PER_PIXEL   = 2,
   parameter int CNT_W             = 12,
   parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
   input  logic                              pix_clk_i,
   input  logic                              rst_n_i,
   input  logic                              enable_i,
   input  logic                              continuous_i,
   input  logic [CNT_W-1:0]                  cfg_width_i,
   input  logic [CNT_W-1:0]                  cfg_height_i,
   input  logic                              err_clear_i,
   input  logic                              cam_pclk_i,
   input  logic                              cam_vsync_i,
   input  logic                              cam_href_i,
   input  logic [DATA_W-1:0]                 cam_data_i,
   output logic [DATA_W*BYTES_PER_PIXEL-1:0] pixel_out_o,
   output logic                              pixel_valid_o,
   output logic                              frame_start_o,
   output logic                              line_end_o,
   output logic [CNT_W-1:0]                  pixel_x_o,
   output logic [CNT_W-1:0]                  pixel_y_o,
   output logic                              frame_end_o,
   output logic                              capturing_o,
   output logic [15:0]                       frame_count_o,
   output logic                              err_line_len_o,
   output logic                              err_line_cnt_o
);
   localparam int         PIX_W   = pix_w(DATA_W, BYTES_PER_PIXEL);
   localparam logic [1:0] PH_LAST = 2'(BYTES_PER_PIXEL - 1);
   cam_state_t        state_q, state_d;
   logic              pclk_rise, href_lvl, href_rise, href_fall, vs_rise, vs_fall;
   logic [DATA_W-1:0] cam_byte;
   logic [1:0]        phase_q, phase_d, cur_ph;
   logic [PIX_W-1:0]  word_q, word_d, hold_q, hold_d;
   logic              hold_vld_q, hold_vld_d, first_q, first_d;
   logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
   logic              fsync_edge, start_frame, in_cap, cap, done_pix, flush, line_cut;
   logic              emit, emit_last, len_err, cnt_err;

   cam_bus_sync #(.DATA_W(DATA_W)) u_sync (
      .clk_i        (pix_clk_i),
      .rst_n_i      (rst_n_i),
      .pclk_i       (cam_pclk_i),
      .vsync_i      (cam_vsync_i),
      .href_i       (cam_href_i),
      .data_i       (cam_data_i),
      .data_o       (cam_byte),
      .href_o       (href_lvl),
      .pclk_rise_o  (pclk_rise),
      .href_rise_o  (href_rise),
      .href_fall_o  (href_fall),
      .vsync_rise_o (vs_rise),
      .vsync_fall_o (vs_fall)
   );

   assign fsync_edge = VSYNC_ACTIVE_HIGH ? vs_rise : vs_fall;

   // frame state register
   always_ff @(posedge pix_clk_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // frame sequencing; enable only matters outside an accepted frame
   always_comb begin
      state_d = (state_q == ST_IDLE)     ? (enable_i ? ST_WAIT_SOF : ST_IDLE) :
                (state_q == ST_WAIT_SOF) ? (!enable_i ? ST_IDLE : fsync_edge ? ST_CAPTURE : ST_WAIT_SOF) :
                (state_q == ST_CAPTURE)  ? (fsync_edge ? ST_FRAME_DONE : ST_CAPTURE) :
                (continuous_i && enable_i) ? ST_CAPTURE : ST_IDLE;
   end

   // state-derived outputs and the frame-accept strobe
   always_comb begin
      capturing_o = (state_q == ST_CAPTURE) || (state_q == ST_FRAME_DONE);
      frame_end_o = (state_q == ST_FRAME_DONE);
      start_frame = (state_q != ST_CAPTURE) && (state_d == ST_CAPTURE);
   end

   // byte packing into a one-deep hold so the last pixel of a line can be tagged once href drops
   always_comb begin
      in_cap     = (state_q == ST_CAPTURE);
      cap        = in_cap && pclk_rise && href_lvl;
      cur_ph     = href_rise ? 2'd0 : phase_q;
      word_d     = cap ? PIX_W'({word_q, cam_byte}) : word_q;
      done_pix   = cap && (cur_ph == PH_LAST);
      flush      = in_cap && fsync_edge && (href_lvl || hold_vld_q);
      line_cut   = in_cap && href_fall;
      emit_last  = flush || line_cut;
      emit       = hold_vld_q && (emit_last || done_pix);
      phase_d    = (done_pix || href_fall || fsync_edge) ? 2'd0 : cap ? cur_ph + 2'd1 : cur_ph;
      hold_d     = done_pix ? word_d : hold_q;
      hold_vld_d = emit_last ? 1'b0 : done_pix ? 1'b1 : hold_vld_q;
      x_d        = start_frame ? '0 : emit ? (emit_last ? '0 : x_q + CNT_W'(1)) : x_q;
      y_d        = start_frame ? '0 : (emit && emit_last) ? y_q + CNT_W'(1) : y_q;
      first_d    = start_frame ? 1'b1 : emit ? 1'b0 : first_q;
      len_err    = (emit && emit_last && (x_q + CNT_W'(1) != cfg_width_i)) || flush ||
                   (line_cut && (phase_q != 2'd0));
      cnt_err    = frame_end_o && (y_q != cfg_height_i);
   end

   // datapath registers, registered stream outputs, frame counter and sticky error flags
   always_ff @(posedge pix_clk_i) begin
      if (!rst_n_i) begin
         phase_q        <= '0;
         word_q         <= '0;
         hold_q         <= '0;
         hold_vld_q     <= 1'b0;
         first_q        <= 1'b0;
         x_q            <= '0;
         y_q            <= '0;
         pixel_out_o    <= '0;
         pixel_valid_o  <= 1'b0;
         frame_start_o  <= 1'b0;
         line_end_o     <= 1'b0;
         pixel_x_o      <= '0;
         pixel_y_o      <= '0;
         frame_count_o  <= '0;
         err_line_len_o <= 1'b0;
         err_line_cnt_o <= 1'b0;
      end else begin
         phase_q        <= phase_d;
         word_q         <= word_d;
         hold_q         <= hold_d;
         hold_vld_q     <= hold_vld_d;
         first_q        <= first_d;
         x_q            <= x_d;
         y_q            <= y_d;
         pixel_valid_o  <= emit;
         frame_start_o  <= emit && first_q;
         line_end_o     <= emit && emit_last;
         if (emit) begin
            pixel_out_o <= hold_q;
            pixel_x_o   <= x_q;
            pixel_y_o   <= y_q;
         end
         if (frame_end_o) frame_count_o <= frame_count_o + 16'd1;
         err_line_len_o <= (err_line_len_o && !err_clear_i) || len_err;
         err_line_cnt_o <= (err_line_cnt_o && !err_clear_i) || cnt_err;
      end
   end
endmodule

// File: tb/tb_cam_capture_stream.sv
// tb_cam_capture_stream: randomized DVP frames checked against a frame-level pixel model
module tb_cam_capture_stream;
   localparam int DW = 8, BPP = 2, CW = 12, PW = DW * BPP;
   typedef logic [DW-1:0] bq_t[$];
   typedef struct {
      logic [PW-1:0] pix;
      logic [CW-1:0] x, y;
      logic          le, fs;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n, enable, continuous, err_clear, pclk, vsync, href;
   logic [CW-1:0] cfg_w, cfg_h;
   logic [DW-1:0] data;
   logic [PW-1:0] pixel_out;
   logic          pixel_valid, frame_start, line_end, frame_end, capturing, err_line_len, err_line_cnt;
   logic [CW-1:0] pixel_x, pixel_y;
   logic [15:0]   frame_count;

   exp_t          q[$];
   logic [PW-1:0] seen[$];
   int            total = 0, bad = 0, fe_seen = 0, hp = 4;
   bit            chk_on = 1'b1, exp_len = 1'b0, exp_cnt = 1'b0;

   always #5 clk = ~clk;

   cam_capture_stream #(.DATA_W(DW), .BYTES_PER_PIXEL(BPP), .CNT_W(CW), .VSYNC_ACTIVE_HIGH(1'b1)) dut (
      .pix_clk_i      (clk),
      .rst_n_i        (rst_n),
      .enable_i       (enable),
      .continuous_i   (continuous),
      .cfg_width_i    (cfg_w),
      .cfg_height_i   (cfg_h),
      .err_clear_i    (err_clear),
      .cam_pclk_i     (pclk),
      .cam_vsync_i    (vsync),
      .cam_href_i     (href),
      .cam_data_i     (data),
      .pixel_out_o    (pixel_out),
      .pixel_valid_o  (pixel_valid),
      .frame_start_o  (frame_start),
      .line_end_o     (line_end),
      .pixel_x_o      (pixel_x),
      .pixel_y_o      (pixel_y),
      .frame_end_o    (frame_end),
      .capturing_o    (capturing),
      .frame_count_o  (frame_count),
      .err_line_len_o (err_line_len),
      .err_line_cnt_o (err_line_cnt)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   // every emitted pixel is matched in order against the model queue
   always @(negedge clk) begin
      if (chk_on && rst_n) begin
         if (frame_end) fe_seen++;
         if (pixel_valid) begin
            seen.push_back(pixel_out);
            if (q.size() == 0) check("spurious_pixel", 64'(pixel_valid), 64'd0);
            else begin
               exp_t e;
               e = q.pop_front();
               check("pixel", 64'(pixel_out), 64'(e.pix));
               check("pixel_x", 64'(pixel_x), 64'(e.x));
               check("pixel_y", 64'(pixel_y), 64'(e.y));
               check("line_end", 64'(line_end), 64'(e.le));
               check("frame_start", 64'(frame_start), 64'(e.fs));
            end
         end else if (line_end || frame_start) check("tag_without_valid", 64'({line_end, frame_start}), 64'd0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 1'b0; continuous = 1'b0; err_clear = 1'b0;
      pclk = 1'b0; vsync = 1'b0; href = 1'b0; data = '0;
      cyc(3);
      rst_n = 1'b1;
      q.delete(); seen.delete();
      fe_seen = 0; exp_len = 1'b0; exp_cnt = 1'b0;
      cyc(2);
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      cyc(4 + $urandom_range(0, 3));
      vsync = 1'b0;
      cyc(4);
   endtask

   task automatic send_line(input bq_t b);
      foreach (b[i]) begin
         pclk = 1'b0; href = 1'b1; data = b[i];
         cyc(hp);
         pclk = 1'b1;
         cyc(hp);
      end
      pclk = 1'b0; href = 1'b0;
      cyc(hp + $urandom_range(2, 6));
   endtask

   // model: each complete group of BPP bytes is one pixel, first byte in the MSBs; the last one closes the line
   task automatic send_frame(input int nl, input int nb, input int nb0, input bit cap, input bit seq, input int drop_line);
      int sc;
      sc = 0;
      for (int l = 0; l < nl; l++) begin
         int n, np;
         bq_t b;
         n = (l == 0) ? nb0 : nb;
         if (l == drop_line) enable = 1'b0;
         for (int i = 0; i < n; i++) begin
            sc++;
            b.push_back(seq ? DW'(sc) : DW'($urandom));
         end
         np = n / BPP;
         if (cap) begin
            for (int i = 0; i < np; i++) begin
               exp_t e;
               e.pix = '0;
               for (int k = 0; k < BPP; k++) e.pix = (e.pix << DW) | PW'(b[i*BPP+k]);
               e.x = CW'(i); e.y = CW'(l);
               e.le = (i == np - 1); e.fs = (l == 0 && i == 0);
               q.push_back(e);
            end
            if (np != int'(cfg_w) || n % BPP != 0) exp_len = 1'b1;
         end
         send_line(b);
      end
      if (cap && nl != int'(cfg_h)) exp_cnt = 1'b1;
   endtask

   task automatic start(input int w, input int h, input bit cont);
      do_reset();
      cfg_w = CW'(w); cfg_h = CW'(h); continuous = cont; enable = 1'b1;
      cyc(2);
      vs_pulse();
   endtask

   initial begin
      cfg_w = '0; cfg_h = '0;
      do_reset();
      rst_n = 1'b0;
      cyc(1);
      check("reset_outputs", 64'({pixel_out, pixel_valid, frame_start, line_end, pixel_x, pixel_y,
            frame_end, capturing, frame_count, err_line_len, err_line_cnt}), 64'd0);
      rst_n = 1'b1;
      // two clean 4x2 frames with a counting byte pattern
      hp = 4;
      start(4, 2, 1'b1);
      send_frame(2, 8, 8, 1'b1, 1'b1, -1); vs_pulse();
      send_frame(2, 8, 8, 1'b1, 1'b1, -1); vs_pulse();
      cyc(4);
      check("t1_frame_count", 64'(frame_count), 64'd2);
      check("t1_frame_end_pulses", 64'(fe_seen), 64'd2);
      check("t1_left", 64'(q.size()), 64'd0);
      check("t1_pixels", 64'(seen.size()), 64'd16);
      check("t1_p0", 64'(seen[0]), 64'h0102);
      check("t1_p3", 64'(seen[3]), 64'h0708);
      check("t1_p7", 64'(seen[7]), 64'h0f10);
      check("t1_p8", 64'(seen[8]), 64'h0102);
      check("t1_errors", 64'({err_line_len, err_line_cnt}), 64'd0);
      check("t1_capturing", 64'(capturing), 64'd1);
      // single shot: the frame after the first is skipped even while still enabled
      hp = 3;
      start(4, 2, 1'b0);
      send_frame(2, 8, 8, 1'b1, 1'b0, -1); vs_pulse();
      send_frame(2, 8, 8, 1'b0, 1'b0, -1);
      enable = 1'b0;
      cyc(2);
      vs_pulse();
      send_frame(2, 8, 8, 1'b0, 1'b0, -1); vs_pulse();
      cyc(4);
      check("t2_frame_count", 64'(frame_count), 64'd1);
      check("t2_pixels", 64'(seen.size()), 64'd8);
      check("t2_capturing", 64'(capturing), 64'd0);
      check("t2_frame_end_pulses", 64'(fe_seen), 64'd1);
      check("t2_left", 64'(q.size()), 64'd0);
      // short line sets a sticky length error that survives until cleared
      start(4, 2, 1'b1);
      send_frame(2, 8, 6, 1'b1, 1'b0, -1); vs_pulse();
      cyc(4);
      check("t3_pixels", 64'(seen.size()), 64'd7);
      check("t3_err_len", 64'(err_line_len), 64'd1);
      check("t3_err_cnt", 64'(err_line_cnt), 64'd0);
      cyc(6);
      check("t3_err_len_sticky", 64'(err_line_len), 64'd1);
      err_clear = 1'b1;
      cyc(1);
      err_clear = 1'b0;
      check("t3_err_len_cleared", 64'(err_line_len), 64'd0);
      // odd byte count drops the trailing partial pixel
      start(4, 2, 1'b1);
      send_frame(2, 8, 7, 1'b1, 1'b0, -1); vs_pulse();
      cyc(4);
      check("t4_pixels", 64'(seen.size()), 64'd7);
      check("t4_err_len", 64'(err_line_len), 64'd1);
      check("t4_left", 64'(q.size()), 64'd0);
      // one line too many
      start(4, 2, 1'b1);
      send_frame(3, 8, 8, 1'b1, 1'b0, -1); vs_pulse();
      cyc(4);
      check("t5_err_cnt", 64'(err_line_cnt), 64'd1);
      check("t5_err_len", 64'(err_line_len), 64'd0);
      check("t5_frame_count", 64'(frame_count), 64'd1);
      // enable dropped mid-frame still finishes the frame, then idles
      start(4, 2, 1'b1);
      send_frame(2, 8, 8, 1'b1, 1'b0, 1); vs_pulse();
      cyc(4);
      check("t6_frame_count", 64'(frame_count), 64'd1);
      check("t6_pixels", 64'(seen.size()), 64'd8);
      check("t6_capturing", 64'(capturing), 64'd0);
      check("t6_errors", 64'({err_line_len, err_line_cnt}), 64'd0);
      // randomized geometry, data and bus timing
      for (int it = 0; it < 8; it++) begin
         int w, h, nf, nb;
         w = $urandom_range(1, 5); h = $urandom_range(1, 3); nf = $urandom_range(1, 2);
         hp = $urandom_range(3, 5);
         nb = w * BPP + (($urandom_range(0, 3) == 0) ? 1 : 0);
         start(($urandom_range(0, 3) == 0) ? w + 1 : w, ($urandom_range(0, 3) == 0) ? h + 1 : h, 1'b1);
         for (int f = 0; f < nf; f++) begin
            send_frame(h, nb, nb, 1'b1, 1'b0, -1);
            vs_pulse();
         end
         cyc(4);
         check("rnd_frame_count", 64'(frame_count), 64'(nf));
         check("rnd_frame_end_pulses", 64'(fe_seen), 64'(nf));
         check("rnd_left", 64'(q.size()), 64'd0);
         check("rnd_err_len", 64'(err_line_len), 64'(exp_len));
         check("rnd_err_cnt", 64'(err_line_cnt), 64'(exp_cnt));
      end
      // reset in the middle of a line clears every output on the next cycle
      hp = 3;
      start(4, 1, 1'b1);
      send_frame(1, 8, 8, 1'b1, 1'b0, -1); vs_pulse();
      cyc(4);
      check("t8_pre_count", 64'(frame_count), 64'd1);
      check("t8_pre_capturing", 64'(capturing), 64'd1);
      chk_on = 1'b0;
      for (int i = 0; i < 5; i++) begin
         pclk = 1'b0; href = 1'b1; data = DW'($urandom);
         cyc(hp);
         pclk = 1'b1;
         cyc(hp);
      end
      rst_n = 1'b0;
      cyc(1);
      check("t8_reset_outputs", 64'({pixel_out, pixel_valid, frame_start, line_end, pixel_x, pixel_y,
            frame_end, capturing, frame_count, err_line_len, err_line_cnt}), 64'd0);
      do_reset();
      chk_on = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
